// File: rtl/ddr_port_arbiter_pkg.sv
// Shared types and constants for the DDR port arbiter and its address generators.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ddr_port_arbiter_pkg;

  // Arbiter FSM: IDLE arbitrates, CMD presents the command, DATA waits for burst_done.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  // Bit positions in the one-hot grant vector.
  localparam int GNT_WR0 = 0;
  localparam int GNT_WR1 = 1;
  localparam int GNT_RD  = 2;

  // Each DDR beat is 64 bits wide.
  localparam int BYTES_PER_BEAT = 8;

endpackage

// File: rtl/ddr_port_addr_gen.sv
// Per-port frame address tracker: beat offset, bank bit, deferred frame_start, byte address.
// Latency: addr is combinational from the registered offset/bank; updates land on the next edge.
// Backpressure: none; a frame_start arriving mid-burst is held until that burst's done pulse.
module ddr_port_addr_gen
  import ddr_port_arbiter_pkg::*;
#(
  parameter int               ADDR_W      = 28,
  parameter int               BURST_BEATS = 64,
  parameter int               FRAME_BEATS = 115200,
  parameter logic [ADDR_W-1:0] BANK_STRIDE = 28'h0400000
) (
  input  logic              ddr_clk,
  input  logic              ddr_rst_n,
  input  logic [ADDR_W-1:0] base,
  input  logic              frame_start,
  input  logic              bank_load,
  input  logic              busy,
  input  logic              done,
  output logic              bank,
  output logic [ADDR_W-1:0] addr
);

  localparam int OFF_W = $clog2(FRAME_BEATS);

  logic [OFF_W-1:0] offset_q;
  logic             bank_q;
  logic             pend_q;
  logic [OFF_W:0]   off_sum;
  logic             apply_fs;

  // New frame takes effect now if this port is idle, else at its burst_done (dropping that advance).
  always_comb begin
    off_sum  = {1'b0, offset_q} + (OFF_W+1)'(BURST_BEATS);
    apply_fs = (frame_start && !busy) || (done && (pend_q || frame_start));
  end

  // Offset, bank and deferred-frame_start state.
  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      offset_q <= '0;
      bank_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      if (apply_fs) begin
        bank_q   <= bank_load;
        offset_q <= '0;
      end else if (done) begin
        offset_q <= (off_sum >= (OFF_W+1)'(FRAME_BEATS)) ? '0 : off_sum[OFF_W-1:0];
      end
      if (apply_fs || done) begin
        pend_q <= 1'b0;
      end else if (frame_start && busy) begin
        pend_q <= 1'b1;
      end
    end
  end

  assign bank = bank_q;
  assign addr = base + (bank_q ? BANK_STRIDE : '0) + ADDR_W'(offset_q) * ADDR_W'(BYTES_PER_BEAT);

endmodule

// File: rtl/ddr_port_arbiter.sv
// Arbitrates two camera write ports and one display read port onto a single DDR command port.
// Latency: cmd_valid one cycle after an IDLE arbitration; next command >= 2 cycles after burst_done.
// Backpressure: command held in CMD until cmd_ready; grant held until burst_done ends DATA.
module ddr_port_arbiter
  import ddr_port_arbiter_pkg::*;
#(
  parameter int                ADDR_W      = 28,
  parameter int                BURST_BEATS = 64,
  parameter int                FRAME_BEATS = 115200,
  parameter logic [ADDR_W-1:0] CAM0_BASE   = 28'h0000000,
  parameter logic [ADDR_W-1:0] CAM1_BASE   = 28'h0800000,
  parameter logic [ADDR_W-1:0] BANK_STRIDE = 28'h0400000
) (
  input  logic              ddr_clk,
  input  logic              ddr_rst_n,
  input  logic              ddr_init_done,
  input  logic              wr0_req,
  input  logic              wr1_req,
  input  logic              wr0_frame_start,
  input  logic              wr1_frame_start,
  input  logic              rd_req,
  input  logic              rd_frame_start,
  input  logic              disp_sel,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [2:0]        grant,
  input  logic              burst_done
);

  arb_state_t        state_q, state_d;
  logic [2:0]        grant_q;
  logic              cmd_write_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic              rr_q;        // 0 favours wr0, 1 favours wr1
  logic              arb_en_q;    // holds off arbitration for one edge after reset release
  logic              disp_sel_q;
  logic [2:0]        pick;
  logic              arb_go;
  logic              done_pulse;
  logic              rd_sel_eff;
  logic [2:0]        port_bank;
  logic [ADDR_W-1:0] port_addr [3];
  logic [ADDR_W-1:0] pick_addr;
  logic [ADDR_W-1:0] rd_base;

  // Winner selection: read first, then round-robin between the writers.
  always_comb begin
    pick = 3'b000;
    if (rd_req) begin
      pick[GNT_RD] = 1'b1;
    end else if (wr0_req && wr1_req) begin
      if (rr_q) pick[GNT_WR1] = 1'b1;
      else      pick[GNT_WR0] = 1'b1;
    end else if (wr0_req) begin
      pick[GNT_WR0] = 1'b1;
    end else if (wr1_req) begin
      pick[GNT_WR1] = 1'b1;
    end
    pick_addr = pick[GNT_RD]  ? port_addr[GNT_RD]  :
                pick[GNT_WR1] ? port_addr[GNT_WR1] : port_addr[GNT_WR0];
  end

  assign arb_go     = (state_q == ST_IDLE) && ddr_init_done && arb_en_q &&
                      (rd_req || wr0_req || wr1_req);
  assign done_pulse = (state_q == ST_DATA) && burst_done;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_go)     state_d = ST_CMD;
      ST_CMD:  if (cmd_ready)  state_d = ST_DATA;
      ST_DATA: if (burst_done) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any burst in flight.
  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Command fields captured at arbitration and held until the burst ends.
  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      grant_q     <= 3'b000;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
    end else if (arb_go) begin
      grant_q     <= pick;
      cmd_write_q <= !pick[GNT_RD];
      cmd_addr_q  <= pick_addr;
    end else if (done_pulse) begin
      grant_q     <= 3'b000;
    end
  end

  // Round-robin pointer moves only when a writer finishes, plus display-select latch and arb enable.
  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      rr_q       <= 1'b0;
      disp_sel_q <= 1'b0;
      arb_en_q   <= 1'b0;
    end else begin
      arb_en_q <= 1'b1;
      if (done_pulse && grant_q[GNT_WR0])      rr_q <= 1'b1;
      else if (done_pulse && grant_q[GNT_WR1]) rr_q <= 1'b0;
      if (rd_frame_start) disp_sel_q <= disp_sel;
    end
  end

  // The read bank is loaded from the selected writer's bank, using the fresh select on an immediate load.
  assign rd_sel_eff = rd_frame_start ? disp_sel : disp_sel_q;
  assign rd_base    = disp_sel_q ? CAM1_BASE : CAM0_BASE;

  ddr_port_addr_gen #(
    .ADDR_W(ADDR_W), .BURST_BEATS(BURST_BEATS), .FRAME_BEATS(FRAME_BEATS), .BANK_STRIDE(BANK_STRIDE)
  ) u_wr0_addr (
    .ddr_clk(ddr_clk), .ddr_rst_n(ddr_rst_n), .base(CAM0_BASE),
    .frame_start(wr0_frame_start), .bank_load(~port_bank[GNT_WR0]),
    .busy(grant_q[GNT_WR0]), .done(done_pulse && grant_q[GNT_WR0]),
    .bank(port_bank[GNT_WR0]), .addr(port_addr[GNT_WR0])
  );

  ddr_port_addr_gen #(
    .ADDR_W(ADDR_W), .BURST_BEATS(BURST_BEATS), .FRAME_BEATS(FRAME_BEATS), .BANK_STRIDE(BANK_STRIDE)
  ) u_wr1_addr (
    .ddr_clk(ddr_clk), .ddr_rst_n(ddr_rst_n), .base(CAM1_BASE),
    .frame_start(wr1_frame_start), .bank_load(~port_bank[GNT_WR1]),
    .busy(grant_q[GNT_WR1]), .done(done_pulse && grant_q[GNT_WR1]),
    .bank(port_bank[GNT_WR1]), .addr(port_addr[GNT_WR1])
  );

  ddr_port_addr_gen #(
    .ADDR_W(ADDR_W), .BURST_BEATS(BURST_BEATS), .FRAME_BEATS(FRAME_BEATS), .BANK_STRIDE(BANK_STRIDE)
  ) u_rd_addr (
    .ddr_clk(ddr_clk), .ddr_rst_n(ddr_rst_n), .base(rd_base),
    .frame_start(rd_frame_start),
    .bank_load(~(rd_sel_eff ? port_bank[GNT_WR1] : port_bank[GNT_WR0])),
    .busy(grant_q[GNT_RD]), .done(done_pulse && grant_q[GNT_RD]),
    .bank(port_bank[GNT_RD]), .addr(port_addr[GNT_RD])
  );

  assign cmd_valid = (state_q == ST_CMD);
  assign cmd_write = cmd_write_q;
  assign cmd_addr  = cmd_addr_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Randomized self-checking bench for ddr_port_arbiter against a burst-level frame/bank model.
// Latency: checks command timing at negedges around each transaction.
// Backpressure: cmd_ready is withheld for random cycles before acceptance.
module tb_ddr_port_arbiter;

  localparam int          AW     = 28;
  localparam int          BEATS  = 64;
  localparam int          FRAME  = 115200;
  localparam logic [27:0] CAM0   = 28'h0000000;
  localparam logic [27:0] CAM1   = 28'h0800000;
  localparam logic [27:0] STRIDE = 28'h0400000;

  logic          ddr_clk = 1'b0;
  logic          ddr_rst_n = 1'b0;
  logic          ddr_init_done = 1'b0;
  logic          wr0_req = 1'b0, wr1_req = 1'b0, rd_req = 1'b0;
  logic          wr0_frame_start = 1'b0, wr1_frame_start = 1'b0, rd_frame_start = 1'b0;
  logic          disp_sel = 1'b0;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    grant;
  logic          burst_done = 1'b0;

  ddr_port_arbiter dut (
    .ddr_clk(ddr_clk), .ddr_rst_n(ddr_rst_n), .ddr_init_done(ddr_init_done),
    .wr0_req(wr0_req), .wr1_req(wr1_req),
    .wr0_frame_start(wr0_frame_start), .wr1_frame_start(wr1_frame_start),
    .rd_req(rd_req), .rd_frame_start(rd_frame_start), .disp_sel(disp_sel),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .grant(grant), .burst_done(burst_done)
  );

  always #5 ddr_clk = ~ddr_clk;

  int          n_chk = 0;
  int          n_err = 0;
  // Reference model: frame position of each port in beats, bank bits, pending frame starts.
  int          m_off [3];
  bit          m_bank[3];
  bit          m_pend[3];
  bit          m_sel;
  int          m_rr;
  bit          chk_lat;
  logic [2:0]  last_grant;
  logic        last_write;
  logic [27:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      m_off[p] = 0; m_bank[p] = 0; m_pend[p] = 0;
    end
    m_sel = 0;
    m_rr  = 0;
  endtask

  function automatic int model_pick();
    if (rd_req) return 2;
    if (wr0_req && wr1_req) return m_rr;
    return wr0_req ? 0 : 1;
  endfunction

  function automatic logic [27:0] model_addr(input int p);
    longint a;
    logic [27:0] base;
    base = (p == 0) ? CAM0 : (p == 1) ? CAM1 : (m_sel ? CAM1 : CAM0);
    a = longint'(base) + (m_bank[p] ? longint'(STRIDE) : 0) + longint'(m_off[p]) * 8;
    return a[27:0];
  endfunction

  task automatic model_new_frame(input int p);
    if (p < 2) m_bank[p] = !m_bank[p];
    else       m_bank[2] = !m_bank[m_sel];
    m_off[p]  = 0;
    m_pend[p] = 0;
  endtask

  task automatic model_fs(input int p, input int g);
    if (p == 2) m_sel = disp_sel;
    if (p == g) m_pend[p] = 1;
    else        model_new_frame(p);
  endtask

  task automatic model_done(input int g);
    if (m_pend[g]) model_new_frame(g);
    else           m_off[g] = (m_off[g] + BEATS) % FRAME;
    if (g < 2) m_rr = 1 - g;
  endtask

  task automatic set_reqs(input int r);
    int v;
    v = r;
    if (v < 0) v = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 7) | 4) : $urandom_range(1, 3);
    wr0_req = v[0]; wr1_req = v[1]; rd_req = v[2];
  endtask

  // One full transaction: wait for the command, check it, accept it, run DATA, finish.
  task automatic run_burst(input int fs_port, input int sel, input int new_reqs);
    int  g, n, wait_cnt;
    bit  seen;
    logic [2:0] exp_g;
    g = model_pick();
    exp_g = 3'(1 << g);
    seen = 0; wait_cnt = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ddr_clk);
      wait_cnt = i + 1;
      if (cmd_valid) seen = 1;
    end
    chk("cmd_valid_seen", 32'(seen), 32'd1);
    if (!seen) return;
    if (chk_lat) chk("next_cmd_latency", wait_cnt, 1);
    last_grant = grant; last_write = cmd_write; last_addr = cmd_addr;
    chk("grant", 32'(grant), 32'(exp_g));
    chk("cmd_write", 32'(cmd_write), (g != 2) ? 32'd1 : 32'd0);
    chk("cmd_addr", 32'(cmd_addr), 32'(model_addr(g)));
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      burst_done = 1'($urandom_range(0, 1));
      @(negedge ddr_clk);
      chk("cmd_hold", {28'd0, cmd_valid, grant}, {28'd0, 1'b1, exp_g});
    end
    burst_done = 1'b0;
    cmd_ready = 1'b1;
    @(negedge ddr_clk);
    cmd_ready = 1'($urandom_range(0, 1));
    chk("cmd_valid_drop", 32'(cmd_valid), 32'd0);
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        set_reqs(new_reqs);
        disp_sel = 1'($urandom_range(0, 1));
        if (fs_port == 0) wr0_frame_start = 1'b1;
        if (fs_port == 1) wr1_frame_start = 1'b1;
        if (fs_port == 2) begin
          if (sel >= 0) disp_sel = 1'(sel);
          rd_frame_start = 1'b1;
        end
        if (fs_port >= 0) model_fs(fs_port, g);
      end
      @(negedge ddr_clk);
      wr0_frame_start = 1'b0; wr1_frame_start = 1'b0; rd_frame_start = 1'b0;
    end
    cmd_ready  = 1'b0;
    burst_done = 1'b1;
    model_done(g);
    @(negedge ddr_clk);
    burst_done = 1'b0;
    chk("grant_clear", 32'(grant), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge ddr_clk);
    ddr_rst_n = 1'b0;
    wr0_req = 0; wr1_req = 0; rd_req = 0; cmd_ready = 0; burst_done = 0;
    model_reset();
    repeat (2) @(negedge ddr_clk);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
    chk("rst_cmd_write", 32'(cmd_write), 32'd0);
    ddr_rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int fs;
    model_reset();
    // Reset state, release hold-off, first bursts and frame-start deferral.
    do_reset();
    ddr_init_done = 1'b1;
    wr0_req = 1'b1;
    @(posedge ddr_clk); #1;
    chk("no_arb_first_edge", 32'(cmd_valid), 32'd0);
    chk_lat = 0;
    run_burst(-1, 0, 1);
    chk("first_grant", 32'(last_grant), 32'h1);
    chk("first_write", 32'(last_write), 32'd1);
    chk("first_addr", 32'(last_addr), 32'h0000000);
    chk_lat = 1;
    run_burst(-1, 0, 1);
    chk("second_addr", 32'(last_addr), 32'h0000200);
    run_burst(0, 0, 1);
    run_burst(-1, 0, 0);
    chk("bank_toggle_addr", 32'(last_addr), 32'h0400000);

    // No grant while DDR is not calibrated.
    ddr_init_done = 1'b0;
    wr0_req = 1'b1;
    repeat (4) begin
      @(negedge ddr_clk);
      chk("init_low_no_cmd", 32'(cmd_valid), 32'd0);
    end
    ddr_init_done = 1'b1;
    chk_lat = 0;
    run_burst(-1, 0, 1);

    // Reset in the middle of a DATA phase.
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ddr_clk);
      if (cmd_valid) seen = 1;
    end
    chk("pre_reset_cmd_seen", 32'(seen), 32'd1);
    cmd_ready = 1'b1;
    @(negedge ddr_clk);
    cmd_ready = 1'b0;
    #2 ddr_rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    wr0_req = 1'b0;
    model_reset();
    @(negedge ddr_clk);
    ddr_rst_n = 1'b1;
    repeat (2) @(negedge ddr_clk);
    chk("post_rst_cmd_addr", 32'(cmd_addr), 32'd0);
    chk("post_rst_idle", 32'(cmd_valid), 32'd0);

    // Read priority, then writer alternation.
    set_reqs(7);
    chk_lat = 0;
    run_burst(-1, 0, 7);
    chk("rd_prio_0", 32'(last_grant), 32'h4);
    chk_lat = 1;
    run_burst(-1, 0, 7);
    chk("rd_prio_1", 32'(last_grant), 32'h4);
    run_burst(-1, 0, 3);
    chk("rd_prio_2", 32'(last_grant), 32'h4);
    for (int k = 0; k < 4; k++) begin
      run_burst(-1, 0, 3);
      chk("rr_seq", 32'(last_grant), (k % 2 == 0) ? 32'h1 : 32'h2);
    end

    // Display bank follows the inverse of the selected camera's bank.
    run_burst(1, 0, 1);
    run_burst(2, 1, 4);
    run_burst(-1, 0, 1);
    chk("rd_sel_write", 32'(last_write), 32'd0);
    chk("rd_sel_addr", 32'(last_addr), 32'h0800000);

    // Random traffic with random frame starts.
    repeat (200) begin
      fs = $urandom_range(0, 7);
      run_burst((fs < 3) ? fs : -1, -1, -1);
    end

    // Full-frame offset wrap on wr1.
    do_reset();
    wr1_req = 1'b1;
    chk_lat = 0;
    run_burst(-1, 0, 2);
    chk_lat = 1;
    repeat (1799) run_burst(-1, 0, 2);
    run_burst(-1, 0, 2);
    chk("wrap_addr", 32'(last_addr), 32'h0800000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
